// File: rtl/ipml_sync_fifo_v2.sv
// ipml_sync_fifo_v2: single-clock FIFO with STD or FWFT read, flush and almost flags.
// Define IPML_SYNC_FIFO_ERR_EN for sticky overflow/underflow flags and err_cnt.
module ipml_sync_fifo_v2 #(
    parameter int    c_DATA_WIDTH       = 32,
    parameter int    c_DEPTH_WIDTH      = 10,
    parameter string c_FIFO_MODE        = "STD",
    parameter int    c_ALMOST_FULL_NUM  = 1020,
    parameter int    c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    wr_en,
    output logic                    wr_full,
    output logic                    almost_full,
    output logic [c_DATA_WIDTH-1:0] rd_data,
    input  logic                    rd_en,
    output logic                    rd_empty,
    output logic                    almost_empty,
`ifdef IPML_SYNC_FIFO_ERR_EN
    output logic                    overflow,
    output logic                    underflow,
    output logic [15:0]             err_cnt,
`endif
    output logic [c_DEPTH_WIDTH:0]  water_level
);
    localparam int DW    = c_DATA_WIDTH;
    localparam int AW    = c_DEPTH_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam bit FWFT  = (c_FIFO_MODE == "FWFT");

    localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_LVL = c_ALMOST_FULL_NUM[AW:0];
    localparam logic [AW:0] AE_LVL = c_ALMOST_EMPTY_NUM[AW:0];

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, lvl_q, lvl_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          af_q, af_d, ae_q, ae_d, ov_q, ov_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_acc, pop, fetch, mem_ne;

    assign mem_ne = (wptr_q != rptr_q);
    assign wr_acc = wr_en && !full_q && !clr;
    assign pop    = rd_en && !empty_q && !clr;
    // STD fetches on pop; FWFT keeps its output stage topped up from memory
    assign fetch  = FWFT ? (mem_ne && (!ov_q || pop) && !clr) : pop;

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + ONE : wptr_q;
        rptr_d  = fetch ? rptr_q + ONE : rptr_q;
        rdata_d = fetch ? mem_q[rptr_q[AW-1:0]] : rdata_q;
        ov_d    = 1'b0;
        if (FWFT) begin
            ov_d = fetch | (ov_q & ~pop);
        end
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            ov_d   = 1'b0;
        end
        // the prefetched word still belongs to the fill level
        lvl_d   = wptr_d - rptr_d + {{AW{1'b0}}, ov_d};
        empty_d = FWFT ? !ov_d : (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) &&
                  (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        if (FWFT) begin
            full_d = lvl_d[AW];
        end
        af_d = (lvl_d >= AF_LVL);
        ae_d = (lvl_d <= AE_LVL);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            lvl_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ov_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lvl_q   <= lvl_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ov_q    <= ov_d;
            rdata_q <= rdata_d;
        end
    end

    assign wr_full      = full_q;
    assign almost_full  = af_q;
    assign rd_empty     = empty_q;
    assign almost_empty = ae_q;
    assign water_level  = lvl_q;
    assign rd_data      = rdata_q;

`ifdef IPML_SYNC_FIFO_ERR_EN
    logic        ovf_q, unf_q, ovf_ev, unf_ev;
    logic [15:0] cnt_q;

    assign ovf_ev = wr_en && full_q;
    assign unf_ev = rd_en && empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            cnt_q <= '0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (ovf_ev) ovf_q <= 1'b1;
            if (unf_ev) unf_q <= 1'b1;
            if ((ovf_ev || unf_ev) && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign err_cnt   = cnt_q;
`endif
endmodule
